// File: rtl/nios_system_carcontrol_nios_oci_dct_ctrl_if.sv
// Trace fragment, flush and output-word handshake bundle for the DCT packing controller.
interface nios_system_carcontrol_nios_oci_dct_ctrl_if;
   logic        dtr_req;
   logic [2:0]  dtr_frag;
   logic        dtr_gnt;
   logic        itr_req;
   logic [2:0]  itr_frag;
   logic        itr_gnt;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [29:0] out_data;
   logic [3:0]  out_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;

   // Controller side
   modport slave (
      input  dtr_req, dtr_frag, itr_req, itr_frag, flush, out_ready,
      output dtr_gnt, itr_gnt, out_valid, out_data, out_count, dct_buffer, dct_count
   );

   // Trace sources and downstream FIFO side
   modport master (
      output dtr_req, dtr_frag, itr_req, itr_frag, flush, out_ready,
      input  dtr_gnt, itr_gnt, out_valid, out_data, out_count, dct_buffer, dct_count
   );
endinterface

// File: rtl/nios_system_carcontrol_nios_oci_dct_ctrl.sv
// DCT trace packing controller: round-robin arbitration between data and
// instruction trace, 3-bit fragment packing into a 30-bit word, and a
// valid/ready hand-off of full or flushed words.
module nios_system_carcontrol_nios_oci_dct_ctrl (
   input  logic clk,
   input  logic reset,
   nios_system_carcontrol_nios_oci_dct_ctrl_if.slave bus
);
   localparam int unsigned FRAG_W  = 3;
   localparam int unsigned SLOTS   = 10;
   localparam int unsigned BUF_W   = FRAG_W * SLOTS;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = 5;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

   state_e             state_q, state_d;
   logic               last_itr_q, last_itr_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [BUF_W-1:0]   out_data_q, out_data_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;

   logic               dtr_gnt_c, itr_gnt_c;
   logic [BUF_W-1:0]   buf_acc;
   logic [CNT_W-1:0]   cnt_acc;
   logic [FRAG_W-1:0]  frag;
   logic [IDX_W-1:0]   slot_idx;

   // Arbitration, packing and next-state decode
   always_comb begin
      state_d     = state_q;
      last_itr_d  = last_itr_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      dtr_gnt_c   = 1'b0;
      itr_gnt_c   = 1'b0;
      buf_acc     = buf_q;
      cnt_acc     = cnt_q;
      frag        = bus.dtr_frag;
      slot_idx    = IDX_W'(cnt_q) * IDX_W'(FRAG_W);

      case (state_q)
         FILL: begin
            // A tie goes to whichever source was not granted last
            dtr_gnt_c = bus.dtr_req && (!bus.itr_req || last_itr_q);
            itr_gnt_c = bus.itr_req && (!bus.dtr_req || !last_itr_q);
            if (itr_gnt_c) begin
               frag = bus.itr_frag;
            end
            if ((dtr_gnt_c || itr_gnt_c) && (cnt_q < CNT_W'(SLOTS))) begin
               buf_acc[slot_idx +: FRAG_W] = frag;
               cnt_acc    = cnt_q + CNT_W'(1);
               last_itr_d = itr_gnt_c;
            end
            if ((cnt_acc == CNT_W'(SLOTS)) || (bus.flush && (cnt_acc != '0))) begin
               out_data_d  = buf_acc;
               out_count_d = cnt_acc;
               out_valid_d = 1'b1;
               buf_d       = '0;
               cnt_d       = '0;
               state_d     = DRAIN;
            end else begin
               buf_d = buf_acc;
               cnt_d = cnt_acc;
            end
         end
         DRAIN: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FILL;
         last_itr_q  <= 1'b1;
         buf_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         last_itr_q  <= last_itr_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign bus.dtr_gnt    = dtr_gnt_c;
   assign bus.itr_gnt    = itr_gnt_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_count  = out_count_q;
   assign bus.dct_buffer = buf_q;
   assign bus.dct_count  = cnt_q;
endmodule
